// File: rtl/io_port_bridge.sv
// Clocked bridge between the processor IO port bus and the rs232_uart peripheral.
// Provides a TX staging FIFO with a paced drain FSM, edge-qualified strobes, status and LED registers.
module io_port_bridge #(
    parameter int unsigned TX_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic [7:0] uart_tx_data,
    output logic       uart_write,
    input  logic       uart_tx_full,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_present,
    output logic       uart_rx_ack,
    output logic [1:0] led_out
);
    localparam int unsigned DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int unsigned PW    = TX_DEPTH_LOG2;
    localparam int unsigned CW    = TX_DEPTH_LOG2 + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    logic          r_wr_q;
    logic          r_rd_q;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [1:0]    r_led;
    logic [7:0]    r_tx_data;
    logic          r_tx_write;
    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_push_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_tx_write_nxt;
    logic [7:0]    w_tx_data_nxt;
    logic [7:0]    w_rd_data;

    // A strobe held for several cycles acts only on its first cycle
    assign w_wr_fire   = IO_write_strobe & ~r_wr_q;
    assign w_rd_fire   = IO_read_strobe & ~r_rd_q;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_req  = w_wr_fire && (IO_port_ID == 8'h01);
    assign w_push_ok   = w_push_req & ~w_full;
    assign w_push_drop = w_push_req & w_full;
    assign w_pop       = w_tx_write_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_q <= 1'b0;
            r_rd_q <= 1'b0;
        end else begin
            r_wr_q <= IO_write_strobe;
            r_rd_q <= IO_read_strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= IO_write_data;
        end
    end

    // FIFO bookkeeping; full is judged on the pre-cycle count so a full push is dropped even with a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_led      <= 2'b00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_fire && (IO_port_ID == 8'h04)) begin
                r_overflow <= 1'b0;
            end
            if (w_wr_fire && (IO_port_ID == 8'h05)) begin
                r_led <= IO_write_data[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tx_write_nxt) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // GAP gives the UART a cycle to raise tx_buffer_full before the next issue
    always_comb begin
        w_tx_write_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (~w_empty & ~uart_tx_full) begin
                    w_tx_write_nxt = 1'b1;
                    w_tx_data_nxt  = r_mem[r_rd_ptr];
                end
            end
            default: begin
                w_tx_write_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_write <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_write <= w_tx_write_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (IO_read_strobe) begin
            case (IO_port_ID)
                8'h01:   w_rd_data = uart_rx_present ? uart_rx_data : 8'h00;
                8'h02:   w_rd_data = {7'b0, uart_rx_present};
                8'h03:   w_rd_data = {7'b0, w_full};
                8'h04:   w_rd_data = {4'b0, r_overflow, w_empty, w_full, uart_rx_present};
                8'h05:   w_rd_data = {6'b0, r_led};
                8'h06:   w_rd_data = 8'(r_count);
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    assign IO_read_data = w_rd_data;
    assign uart_rx_ack  = w_rd_fire && (IO_port_ID == 8'h01) && uart_rx_present;
    assign uart_tx_data = r_tx_data;
    assign uart_write   = r_tx_write;
    assign led_out      = r_led;

endmodule

// File: tb/tb_io_port_bridge.sv
// Randomized self-checking bench for io_port_bridge against a queue-based model of the port map.
// Inputs change just after the falling edge; outputs are sampled at or just after the falling edge.
module tb_io_port_bridge;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic [7:0] uart_tx_data;
    logic       uart_write;
    logic       uart_tx_full;
    logic [7:0] uart_rx_data;
    logic       uart_rx_present;
    logic       uart_rx_ack;
    logic [1:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic [1:0] m_led;
    logic       prev_write = 1'b0;

    io_port_bridge #(.TX_DEPTH_LOG2(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .uart_tx_data    (uart_tx_data),
        .uart_write      (uart_write),
        .uart_tx_full    (uart_tx_full),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_present (uart_rx_present),
        .uart_rx_ack     (uart_rx_ack),
        .led_out         (led_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] id);
        int  n;
        logic full, empty;
        n     = exp_q.size();
        full  = (n == DEPTH);
        empty = (n == 0);
        case (id)
            8'h01:   return uart_rx_present ? uart_rx_data : 8'h00;
            8'h02:   return {7'b0, uart_rx_present};
            8'h03:   return {7'b0, full};
            8'h04:   return {4'b0, m_ovf, empty, full, uart_rx_present};
            8'h05:   return {6'b0, m_led};
            8'h06:   return 8'(n);
            default: return 8'h00;
        endcase
    endfunction

    // Every byte leaving the bridge must be the oldest accepted one, paced and only when the UART has room
    always @(negedge clk) begin
        if (!reset) begin
            if (uart_write) begin
                check_eq("tx_gap", {7'b0, prev_write}, 8'h00);
                check_eq("tx_while_full", {7'b0, uart_tx_full}, 8'h00);
                if (exp_q.size() > 0) check_eq("tx_data", uart_tx_data, exp_q.pop_front());
                else check_eq("tx_spurious", {7'b0, uart_write}, 8'h00);
            end else begin
                check_eq("tx_idle_data", uart_tx_data, 8'h00);
            end
        end
        prev_write = uart_write;
    end

    task automatic io_write(input logic [7:0] id, input logic [7:0] data, input int hold);
        @(negedge clk); #1;
        IO_port_ID = id; IO_write_data = data; IO_write_strobe = 1'b1;
        if (id == 8'h01) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else m_ovf = 1'b1;
        end else if (id == 8'h04) begin
            m_ovf = 1'b0;
        end else if (id == 8'h05) begin
            m_led = data[1:0];
        end
        repeat (hold - 1) @(negedge clk);
        @(negedge clk); #1;
        IO_write_strobe = 1'b0;
        check_eq("led_out", {6'b0, led_out}, {6'b0, m_led});
    endtask

    task automatic io_read(input logic [7:0] id, input int hold);
        @(negedge clk); #1;
        IO_port_ID = id; IO_read_strobe = 1'b1;
        #1;
        check_eq("rd_data", IO_read_data, model_rd(id));
        check_eq("rx_ack_first", {7'b0, uart_rx_ack}, {7'b0, (id == 8'h01) && uart_rx_present});
        for (int i = 1; i < hold; i++) begin
            @(negedge clk); #2;
            check_eq("rd_data_hold", IO_read_data, model_rd(id));
            check_eq("rx_ack_hold", {7'b0, uart_rx_ack}, 8'h00);
        end
        @(negedge clk); #1;
        IO_read_strobe = 1'b0;
        #1;
        check_eq("rd_idle", IO_read_data, 8'h00);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check_eq("drain_done", 8'(exp_q.size()), 8'h00);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        IO_port_ID = 8'h00; IO_write_data = 8'h00;
        IO_write_strobe = 1'b0; IO_read_strobe = 1'b0;
        uart_tx_full = 1'b0; uart_rx_data = 8'h00; uart_rx_present = 1'b0;
        m_ovf = 1'b0; m_led = 2'b00;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_tx_write", {7'b0, uart_write}, 8'h00);
        check_eq("rst_tx_data", uart_tx_data, 8'h00);
        check_eq("rst_rx_ack", {7'b0, uart_rx_ack}, 8'h00);
        check_eq("rst_led", {6'b0, led_out}, 8'h00);
        check_eq("rst_rd_data", IO_read_data, 8'h00);
        io_read(8'h04, 1);
        check_eq("rst_status", {4'b0, m_ovf, exp_q.size() == 0, 1'b0, 1'b0}, 8'h04);
        io_read(8'h06, 1);

        // Push-to-issue latency, then ordered drain of three bytes
        io_write(8'h01, 8'h41, 1);
        check_eq("lat_pre", {7'b0, uart_write}, 8'h00);
        @(negedge clk);
        check_eq("lat_issue", {7'b0, uart_write}, 8'h01);
        check_eq("lat_data", uart_tx_data, 8'h41);
        io_write(8'h01, 8'h42, 1);
        io_write(8'h01, 8'h43, 1);
        wait_drain(40);
        io_read(8'h06, 1);

        // Fill past depth with the UART stalled
        #1 uart_tx_full = 1'b1;
        for (int b = 0; b < 9; b++) io_write(8'h01, 8'(b), 1);
        io_read(8'h03, 1);
        io_read(8'h06, 1);
        io_read(8'h04, 1);
        check_eq("ovf_status_const", model_rd(8'h04), 8'h0A);
        @(negedge clk); #1 uart_tx_full = 1'b0;
        wait_drain(60);
        io_write(8'h04, 8'hFF, 1);
        io_read(8'h04, 1);

        // RX path with a held read strobe
        @(negedge clk); #1 uart_rx_present = 1'b1; uart_rx_data = 8'h5A;
        io_read(8'h01, 3);
        @(negedge clk); #1 uart_rx_present = 1'b0;
        io_read(8'h01, 3);

        io_write(8'h05, 8'h03, 1);
        check_eq("led_const", {6'b0, led_out}, 8'h03);
        io_read(8'h05, 1);

        // Random mix of pushes, stalls, port writes and reads
        for (int it = 0; it < 300; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: io_write(8'h01, 8'($urandom), int'($urandom_range(1, 3)));
                3: begin
                    logic [7:0] ids [8];
                    ids = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
                    io_write(ids[$urandom_range(0, 7)], 8'($urandom), int'($urandom_range(1, 3)));
                end
                4: begin
                    @(negedge clk); #1 uart_tx_full = ($urandom_range(0, 2) == 0);
                end
                5, 6: begin
                    @(negedge clk); #1;
                    uart_rx_present = 1'($urandom);
                    uart_rx_data    = 8'($urandom);
                    io_read(8'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
                end
                default: repeat ($urandom_range(1, 4)) @(negedge clk);
            endcase
        end
        @(negedge clk); #1 uart_tx_full = 1'b0;
        wait_drain(100);
        io_read(8'h06, 1);
        io_read(8'h04, 1);

        // Reset during an active drain discards everything
        @(negedge clk); #1 uart_tx_full = 1'b1;
        for (int b = 0; b < 5; b++) io_write(8'h01, 8'(8'h90 + b), 1);
        @(negedge clk); #1 uart_tx_full = 1'b0;
        for (int i = 0; i < 20 && !uart_write; i++) @(negedge clk);
        check_eq("rst_issue_seen", {7'b0, uart_write}, 8'h01);
        #1 reset = 1'b1;
        #1 check_eq("rst_cut_write", {7'b0, uart_write}, 8'h00);
        exp_q.delete(); m_ovf = 1'b0; m_led = 2'b00;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        io_read(8'h06, 1);
        io_read(8'h04, 1);
        check_eq("post_rst_led", {6'b0, led_out}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Clocked I/O bridge between the processor's IO port bus (`IO_port_ID`, `IO_write_data`, `IO_read_data`, strobes) and the `rs232_uart` peripheral. It replaces the purely combinational port decode in `top`. It adds an 8-deep TX staging FIFO that drains into the UART whenever the UART can accept data, single-pulse RX acknowledge generation, a status/overflow register and an LED output register.

## Interface
- `TX_DEPTH_LOG2`, default 3: log2 of TX FIFO depth (depth 8); valid range 1-4.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `IO_port_ID` input 8: port address from processor.
- `IO_write_data` input 8: write data from processor.
- `IO_write_strobe` input 1: processor write strobe.
- `IO_read_strobe` input 1: processor read strobe.
- `IO_read_data` output 8: read data to processor; combinational from port ID and registered state, 0x00 when `IO_read_strobe` low.
- `uart_tx_data` output 8: byte to UART; registered; 0x00 when `uart_write` low.
- `uart_write` output 1: one-cycle write pulse to UART (`write_tx_data`); registered.
- `uart_tx_full` input 1: UART `tx_buffer_full`.
- `uart_rx_data` input 8: UART `rx_data_out`.
- `uart_rx_present` input 1: UART `rx_data_present`.
- `uart_rx_ack` output 1: one-cycle pulse to UART `read_rx_data_ack`; combinational.
- `led_out` output 2: LED register.

## Operation
- Strobe qualification: registered copies `wr_q`, `rd_q` of the strobes.
  - Write action fires only when `IO_write_strobe & ~wr_q`.
  - Read side effects fire only when `IO_read_strobe & ~rd_q`.
  - A strobe held N cycles acts once. `IO_read_data` stays valid for the whole strobe.
- Port map, writes:
  - 0x01: push `IO_write_data` into TX FIFO.
  - 0x04: any data clears `overflow`.
  - 0x05: `led_out <= IO_write_data[1:0]`.
  - Other IDs: ignored.
- Port map, reads:
  - 0x01: `uart_rx_data` if `uart_rx_present`, else 0x00. `uart_rx_ack` pulses on the qualified edge only if `uart_rx_present` is high.
  - 0x02: `{7'b0, uart_rx_present}`.
  - 0x03: `{7'b0, fifo_full}` (the FIFO's full flag, not the UART's).
  - 0x04: `{4'b0, overflow, fifo_empty, fifo_full, uart_rx_present}`.
  - 0x05: `{6'b0, led_out}`.
  - 0x06: `{3'b0, count}`, zero-extended to 8 bits.
  - Other IDs: 0x00.
- TX FIFO:
  - Circular buffer with `wr_ptr`, `rd_ptr` (TX_DEPTH_LOG2 bits, wrap modulo depth) and `count` (TX_DEPTH_LOG2+1 bits).
  - `fifo_full = (count == DEPTH)`; `fifo_empty = (count == 0)`.
- Push rules:
  - Push is accepted only if `count < DEPTH`, evaluated on pre-cycle `count`.
  - A push while full is dropped and sets sticky `overflow`. FIFO contents are unchanged.
  - Full + push + pop in the same cycle: push dropped, overflow set, count becomes DEPTH-1.
  - Non-full push + pop in the same cycle: both happen, count unchanged.
- Drain FSM, 2 states:
  - IDLE: if `~fifo_empty & ~uart_tx_full`, register `uart_tx_data <= mem[rd_ptr]`, `uart_write <= 1`, pop, go to GAP.
  - GAP: `uart_write <= 0`, `uart_tx_data <= 0`, return to IDLE unconditionally.
  - The GAP cycle lets the UART update `tx_buffer_full` before the next issue. Maximum drain rate is 1 byte per 2 cycles.
- Overflow clear (port 0x04 write) and overflow set in the same cycle: set wins.

## Timing
- Reset values: `IO_read_data` 0x00 (strobe low), `uart_tx_data` 0x00, `uart_write` 0, `uart_rx_ack` 0, `led_out` 2'b00. FIFO is empty, pointers are 0, `overflow` is 0, FSM is in IDLE, `wr_q`/`rd_q` are 0.
- Reset mid-operation: FIFO contents are discarded. Any `uart_write` pulse in flight is cut off immediately (async).
- Write to 0x01 at edge T with empty FIFO and UART not full:
  - `count` = 1 after edge T.
  - FSM issues at edge T+1; `uart_write` is high during cycle T+1..T+2; `count` = 0 after T+1.
  - Push-to-UART-write latency: 1 cycle.
- LED write at edge T: `led_out` updates after edge T.
- `uart_rx_ack`: high only in the first cycle of a read strobe to 0x01, same cycle as the data, so the processor samples data before the UART advances.
- `uart_tx_full` high in IDLE: FSM holds with no issue. It issues on the first edge where the flag is seen low.

## Test plan
- Reset then idle: all outputs zero; read 0x04 returns 0x04 (empty only); read 0x06 returns 0x00.
- Write 0x41, 0x42, 0x43 to port 0x01 on consecutive strobes, `uart_tx_full` = 0 → three `uart_write` pulses carrying 0x41, 0x42, 0x43 in order, each separated by at least one low cycle; FIFO ends empty.
- Hold `uart_tx_full` = 1, write 9 bytes (0x00-0x08) → 0x03 reads 0x01; 0x06 reads 0x08; 0x04 reads 0x0A (overflow + full). Release full → exactly bytes 0x00-0x07 emitted; write 0x04 → overflow clears, 0x04 reads 0x04.
- `uart_rx_present` = 1, `uart_rx_data` = 0x5A, read strobe to 0x01 held 3 cycles → `IO_read_data` = 0x5A all 3 cycles, `uart_rx_ack` high 1 cycle only. Repeat with present = 0 → data 0x00, no ack.
- Write 0x03 to 0x05 → `led_out` = 2'b11; read 0x05 returns 0x03.
- Assert `reset` with 5 bytes queued mid-drain → `uart_write` drops immediately; after release count = 0, no further writes.
